// File: rtl/ofmap_requant.sv
// Requantizes 8-lane int32 partial sums to packed int8 words through a 3-stage pipeline and a small output FIFO.
// Build option: define OFMAP_RELU_EN to clamp negative results to zero before the zero point is added.
module ofmap_requant #(
  parameter int LANES      = 8,
  parameter int ACC_W      = 32,
  parameter int MULT_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [ACC_W-1:0]  in_acc    [LANES],
  input  logic signed [MULT_W-1:0] cfg_mult  [LANES],
  input  logic [4:0]               cfg_shift [LANES],
  input  logic signed [7:0]        cfg_zp,
  input  logic [15:0]              cfg_count,
  output logic                     out_valid,
  output logic [LANES*8-1:0]       out_data,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     almost_full,
  output logic                     overflow
);

  localparam int PROD_W = ACC_W + MULT_W;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = AW + 1;
  localparam int WORD_W = LANES * 8 + 1;

  // Round-half-up arithmetic shift; one guard bit keeps the rounding add from overflowing.
  function automatic logic signed [PROD_W:0] round_shift(
    input logic signed [PROD_W-1:0] p,
    input logic [4:0]               s
  );
    logic signed [PROD_W:0] ext;
    logic signed [PROD_W:0] rnd;
    ext = {p[PROD_W-1], p};
    rnd = '0;
    if (s != 5'd0) rnd = (PROD_W + 1)'(1) << (s - 5'd1);
    return (ext + rnd) >>> s;
  endfunction

  function automatic logic [7:0] requant(
    input logic signed [PROD_W:0] r,
    input logic signed [7:0]      zp
  );
    logic signed [PROD_W+1:0] rr;
    logic signed [PROD_W+1:0] v;
    logic                     sat_hi;
    logic                     sat_lo;
    rr = {r[PROD_W], r};
`ifdef OFMAP_RELU_EN
    if (rr[PROD_W+1]) rr = '0;
`endif
    v      = rr + {{(PROD_W - 6){zp[7]}}, zp};
    sat_hi = !v[PROD_W+1] && (|v[PROD_W:7]);
    sat_lo = v[PROD_W+1] && !(&v[PROD_W:7]);
    if (sat_hi)      return 8'h7F;
    else if (sat_lo) return 8'h80;
    else             return v[7:0];
  endfunction

  logic                     s1_valid_reg, s2_valid_reg, s3_valid_reg;
  logic signed [PROD_W-1:0] prod_next [LANES];
  logic signed [PROD_W-1:0] prod_reg  [LANES];
  logic [4:0]               shift_reg [LANES];
  logic signed [7:0]        zp_s1_reg, zp_s2_reg;
  logic signed [PROD_W:0]   r_next [LANES];
  logic signed [PROD_W:0]   r_reg  [LANES];
  logic [LANES*8-1:0]       word_next, word_reg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [PROD_W-1:0] acc_ext;
      logic signed [PROD_W-1:0] mult_ext;
      assign acc_ext                = {{MULT_W{in_acc[gi][ACC_W-1]}}, in_acc[gi]};
      assign mult_ext               = {{ACC_W{cfg_mult[gi][MULT_W-1]}}, cfg_mult[gi]};
      assign prod_next[gi]          = acc_ext * mult_ext;
      assign r_next[gi]             = round_shift(prod_reg[gi], shift_reg[gi]);
      assign word_next[8*gi +: 8]   = requant(r_reg[gi], zp_s2_reg);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s3_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= in_valid;
      s2_valid_reg <= s1_valid_reg;
      s3_valid_reg <= s2_valid_reg;
    end
  end

  // Datapath registers only load behind a valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int i = 0; i < LANES; i++) begin
        prod_reg[i]  <= prod_next[i];
        shift_reg[i] <= cfg_shift[i];
      end
      zp_s1_reg <= cfg_zp;
    end
    if (s1_valid_reg) begin
      for (int i = 0; i < LANES; i++) r_reg[i] <= r_next[i];
      zp_s2_reg <= zp_s1_reg;
    end
    if (s2_valid_reg) word_reg <= word_next;
  end

  logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic [15:0]       tile_cnt_reg;
  logic              overflow_reg, almost_full_reg;
  logic              full, rd_en, wr_en, drop, last_tag;
  logic [WORD_W-1:0] head;
  logic [CW+1:0]     pending;

  assign full      = (count_reg == CW'(FIFO_DEPTH));
  assign out_valid = (count_reg != '0);
  assign rd_en     = out_valid && out_ready;
  assign wr_en     = s3_valid_reg && (!full || rd_en);
  assign drop      = s3_valid_reg && full && !rd_en;
  // cfg_count of 0 wraps to 0xFFFF here, giving a 65536-vector tile.
  assign last_tag  = (tile_cnt_reg == cfg_count - 16'd1);
  assign head      = fifo_mem[rd_ptr_reg];
  assign out_data  = out_valid ? head[LANES*8-1:0] : '0;
  assign out_last  = out_valid && head[WORD_W-1];
  assign pending   = (CW+2)'(count_reg) + (CW+2)'(s1_valid_reg)
                   + (CW+2)'(s2_valid_reg) + (CW+2)'(s3_valid_reg);

  assign almost_full = almost_full_reg;
  assign overflow    = overflow_reg;

  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_ptr_reg] <= {last_tag, word_reg};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      tile_cnt_reg    <= '0;
      overflow_reg    <= 1'b0;
      almost_full_reg <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg   <= wr_ptr_reg + AW'(1);
        tile_cnt_reg <= last_tag ? 16'd0 : tile_cnt_reg + 16'd1;
      end
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if (drop) overflow_reg <= 1'b1;
      almost_full_reg <= (pending >= (CW+2)'(FIFO_DEPTH - 1));
    end
  end

endmodule

// File: tb/tb_ofmap_requant.sv
// Directed bench for ofmap_requant: stimulus pushes expected words into a queue, a negedge monitor pops and compares.
module tb_ofmap_requant;

`ifdef OFMAP_RELU_EN
  localparam int NEG_Z0 = 0;
  localparam int NEG_Z5 = 5;
`else
  localparam int NEG_Z0 = 128;
  localparam int NEG_Z5 = 128;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [31:0] in_acc    [8];
  logic signed [15:0] cfg_mult  [8];
  logic [4:0]         cfg_shift [8];
  logic signed [7:0]  cfg_zp;
  logic [15:0]        cfg_count;
  logic               out_valid;
  logic [63:0]        out_data;
  logic               out_last;
  logic               out_ready = 1'b0;
  logic               almost_full;
  logic               overflow;

  logic [64:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ofmap_requant dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_acc(in_acc),
    .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_zp(cfg_zp), .cfg_count(cfg_count),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .almost_full(almost_full), .overflow(overflow)
  );

  task automatic check_bit(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  task automatic check_word(input string name, input logic [64:0] act, input logic [64:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got last=%b data=%h, expected last=%b data=%h",
               name, act[64], act[63:0], req[64], req[63:0]);
    end
  endtask

  task automatic check_reset(input string tag);
    check_bit({tag, "_out_valid"}, out_valid, 1'b0);
    check_word({tag, "_out_data"}, {1'b0, out_data}, 65'd0);
    check_bit({tag, "_out_last"}, out_last, 1'b0);
    check_bit({tag, "_almost_full"}, almost_full, 1'b0);
    check_bit({tag, "_overflow"}, overflow, 1'b0);
  endtask

  // Lanes 1..7 carry a fixed pattern: +10*i on even lanes, -10*i on odd lanes, mult 1, shift 0.
  function automatic logic [7:0] lane_byte(input int i, input int zp);
    int v;
    v = (i % 2 == 1) ? -10 * i : 10 * i;
`ifdef OFMAP_RELU_EN
    if (v < 0) v = 0;
`endif
    v = v + zp;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return 8'(v);
  endfunction

  task automatic set_cfg(input int m0, input int s0, input int zp, input int cnt);
    cfg_mult[0]  = 16'(m0);
    cfg_shift[0] = 5'(s0);
    cfg_zp       = 8'(zp);
    cfg_count    = 16'(cnt);
  endtask

  task automatic send(input int acc0, input int exp0, input bit last, input bit push);
    logic [63:0] w;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_acc[0] = acc0;
    for (int i = 1; i < 8; i++) in_acc[i] = (i % 2 == 1) ? -10 * i : 10 * i;
    if (push) begin
      w[7:0] = 8'(exp0);
      for (int i = 1; i < 8; i++) w[8*i +: 8] = lane_byte(i, int'(cfg_zp));
      exp_q.push_back({last, w});
      $display("issue acc0=%0d zp=%0d -> expect lane0=%02h last=%0d", acc0, cfg_zp, 8'(exp0), last);
    end else begin
      $display("issue acc0=%0d (not expected to reach the output)", acc0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max_cycles) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d words still pending after %0d cycles, expected 0", exp_q.size(), k);
    end
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got last=%b data=%h, expected no word", out_last, out_data);
      end else begin
        $display("output last=%b data=%h", out_last, out_data);
        check_word("word", {out_last, out_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      in_acc[i]    = 32'sd0;
      cfg_mult[i]  = 16'sd1;
      cfg_shift[i] = 5'd0;
    end
    set_cfg(1, 0, 0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;

    // Basic path and latency: in_valid at t, out_valid low at t+3 and high at t+4
    set_cfg(16384, 15, 3, 0);
    send(100, 53, 1'b0, 1'b1);
    idle(1);
    repeat (2) @(negedge clk);
    @(negedge clk);
    check_bit("latency_t3", out_valid, 1'b0);
    @(negedge clk);
    check_bit("latency_t4", out_valid, 1'b1);
    idle(4);

    // Rounding
    set_cfg(1, 1, 0, 0);
    send(3, 2, 1'b0, 1'b1);
    send(-3, 255, 1'b0, 1'b1);
    idle(6);

    // Zero shift and saturation
    set_cfg(1, 0, 0, 0);
    send(7, 7, 1'b0, 1'b1);
    send(1000, 127, 1'b0, 1'b1);
    send(-1000, NEG_Z0, 1'b0, 1'b1);
    idle(6);
    set_cfg(1, 0, 5, 0);
    send(-1000, NEG_Z5, 1'b0, 1'b1);
    send(122, 127, 1'b0, 1'b1);
    send(123, 127, 1'b0, 1'b1);
    send(-133, NEG_Z5, 1'b0, 1'b1);
    send(50, 55, 1'b0, 1'b1);
    idle(6);
    wait_drain(20);

    // Tile boundary with cfg_count = 3
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    set_cfg(1, 0, 0, 3);
    for (int k = 1; k <= 7; k++) send(k, k, bit'(k % 3 == 0), 1'b1);
    idle(1);
    send(8, 8, 1'b0, 1'b1);
    send(9, 9, 1'b1, 1'b1);
    idle(6);
    wait_drain(20);

    // Backpressure and overflow: 5 writes into a 4-deep FIFO
    @(posedge clk); #1; rst = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    for (int k = 1; k <= 5; k++) send(10 + k, 10 + k, bit'(k == 3), bit'(k <= 4));
    idle(1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_bit("ovf_before_5th", overflow, 1'b0);
    check_bit("almost_full_set", almost_full, 1'b1);
    check_bit("full_valid", out_valid, 1'b1);
    check_word("head_hold", {out_last, out_data}, exp_q[0]);
    @(negedge clk);
    check_bit("ovf_after_5th", overflow, 1'b1);
    check_word("head_hold2", {out_last, out_data}, exp_q[0]);
    @(posedge clk); #1; out_ready = 1'b1;
    wait_drain(20);
    check_bit("ovf_sticky", overflow, 1'b1);
    // The dropped word must not have advanced the tile counter
    send(16, 16, 1'b0, 1'b1);
    send(17, 17, 1'b1, 1'b1);
    idle(6);
    wait_drain(20);

    // Reset with two words in the FIFO and two in the pipeline
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send(20 + k, 0, 1'b0, 1'b0);
    idle(1);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check_bit("pre_reset_valid", out_valid, 1'b1);
    @(negedge clk);
    check_reset("midreset");
    @(posedge clk); #1; rst = 1'b1; out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check_bit("no_stale_valid", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
